// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustively walks every input vector of an N_IN-input boolean function that
// is described twice: as a minterm mask (sum of products) and as a maxterm mask
// (product of sums). Both masks are snapshotted on start. Each vector is held
// for STEP cycles while the SoP and PoS values for it are presented. Vectors on
// which the two forms disagree are counted, and the lowest such vector is kept.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active high
//   start          begin a sweep (honoured only in IDLE or DONE)
//   min_mask       bit i set -> function is 1 at vector i (SoP form)
//   max_mask       bit i set -> function is 0 at vector i (PoS form)
//   vec            vector currently presented (MSB = first variable)
//   s_sop, s_pos   SoP / PoS value at vec
//   valid          vec, s_sop and s_pos are meaningful
//   busy           sweep in progress
//   done           one-cycle pulse when the sweep completes
//   mismatch_cnt   number of vectors where the two forms disagree
//   err_flag       at least one disagreement in the current/last sweep
//   first_err_idx  lowest disagreeing vector, 0 when err_flag is 0
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
   parameter int N_IN = 4,
   parameter int STEP = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [(1<<N_IN)-1:0]   min_mask,
   input  logic [(1<<N_IN)-1:0]   max_mask,
   output logic [N_IN-1:0]        vec,
   output logic                   s_sop,
   output logic                   s_pos,
   output logic                   valid,
   output logic                   busy,
   output logic                   done,
   output logic [N_IN:0]          mismatch_cnt,
   output logic                   err_flag,
   output logic [N_IN-1:0]        first_err_idx
);

   localparam int NV = 1 << N_IN;
   // A 1-bit hold counter is kept even for STEP=1 so the logic stays uniform.
   localparam int HW = (STEP > 1) ? $clog2(STEP) : 1;

   localparam logic [HW-1:0]   HOLD_LAST = HW'(STEP - 1);
   localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
   localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(NV - 1);
   localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
   localparam logic [N_IN:0]   CNT_ONE   = (N_IN + 1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NV-1:0]     min_q, min_d;
   logic [NV-1:0]     max_q, max_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic              sop_q, sop_d;
   logic              pos_q, pos_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [N_IN:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [N_IN-1:0]   first_q, first_d;
   logic [N_IN-1:0]   vec_nxt_s;

   // Next-state and next-output computation for the sweep FSM.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      max_d     = max_q;
      vec_d     = vec_q;
      hold_d    = hold_q;
      sop_d     = sop_q;
      pos_d     = pos_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      err_d     = err_q;
      first_d   = first_q;
      vec_nxt_s = vec_q + VEC_ONE;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SWEEP;
               min_d   = min_mask;
               max_d   = max_mask;
               cnt_d   = '0;
               err_d   = 1'b0;
               first_d = '0;
               vec_d   = '0;
               hold_d  = '0;
               // Snapshot is being loaded this edge, so vector 0 is read from the inputs.
               sop_d   = min_mask[0];
               pos_d   = ~max_mask[0];
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         SWEEP: begin
            if (hold_q == HOLD_LAST) begin
               // sop_q/pos_q are aligned with vec_q, so they are compared directly.
               if (sop_q != pos_q) begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (!err_q) begin
                     err_d   = 1'b1;
                     first_d = vec_q;
                  end else begin
                     err_d   = err_q;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
               if (vec_q == VEC_LAST) begin
                  state_d = DONE;
                  hold_d  = '0;
                  sop_d   = 1'b0;
                  pos_d   = 1'b0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  vec_d   = vec_nxt_s;
                  hold_d  = '0;
                  sop_d   = min_q[vec_nxt_s];
                  pos_d   = ~max_q[vec_nxt_s];
               end
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         min_q   <= '0;
         max_q   <= '0;
         vec_q   <= '0;
         hold_q  <= '0;
         sop_q   <= 1'b0;
         pos_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         first_q <= '0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         max_q   <= max_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         sop_q   <= sop_d;
         pos_q   <= pos_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         first_q <= first_d;
      end
   end

   assign vec           = vec_q;
   assign s_sop         = sop_q;
   assign s_pos         = pos_q;
   assign valid         = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign mismatch_cnt  = cnt_q;
   assign err_flag      = err_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// Bench for truth_table_sweeper. Two instances (STEP=1 and STEP=2, N_IN=4)
// share one clock. Stimulus pushes the full expected output stream of a sweep
// into a per-instance queue; a monitor per instance pops and compares on every
// cycle where the DUT presents valid or done, and otherwise checks that the
// held results match the last completed sweep (or zero after reset).
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

   typedef struct packed {
      logic       is_done;
      logic [3:0] vec;
      logic       sop;
      logic       pos;
      logic [4:0] cnt;
      logic       err;
      logic [3:0] first;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s[2];
   logic        start_s[2];
   logic [15:0] min_s[2];
   logic [15:0] max_s[2];
   logic [3:0]  vec_o[2];
   logic        sop_o[2];
   logic        pos_o[2];
   logic        valid_o[2];
   logic        busy_o[2];
   logic        done_o[2];
   logic [4:0]  cnt_o[2];
   logic        err_o[2];
   logic [3:0]  first_o[2];

   rec_t exp_q[2][$];
   rec_t held[2];

   int checks = 0;
   int failures = 0;

   truth_table_sweeper #(.N_IN(4), .STEP(1)) u_dut1 (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
      .min_mask(min_s[0]), .max_mask(max_s[0]),
      .vec(vec_o[0]), .s_sop(sop_o[0]), .s_pos(pos_o[0]),
      .valid(valid_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .mismatch_cnt(cnt_o[0]), .err_flag(err_o[0]), .first_err_idx(first_o[0])
   );

   truth_table_sweeper #(.N_IN(4), .STEP(2)) u_dut2 (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
      .min_mask(min_s[1]), .max_mask(max_s[1]),
      .vec(vec_o[1]), .s_sop(sop_o[1]), .s_pos(pos_o[1]),
      .valid(valid_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .mismatch_cnt(cnt_o[1]), .err_flag(err_o[1]), .first_err_idx(first_o[1])
   );

   // Reference: every vector shown STEP times with the statistics gathered
   // from the vectors before it, then one done record with final statistics.
   task automatic push_sweep(input int d, input logic [15:0] mn, input logic [15:0] mx);
      int   cnt = 0;
      logic err = 1'b0;
      int   first = 0;
      rec_t r;
      for (int k = 0; k < 16; k++) begin
         for (int s = 0; s < d + 1; s++) begin
            r = '{1'b0, 4'(k), mn[k], ~mx[k], 5'(cnt), err, 4'(first)};
            exp_q[d].push_back(r);
         end
         if (mn[k] != ~mx[k]) begin
            if (!err) first = k;
            err = 1'b1;
            cnt++;
         end
      end
      r = '{1'b1, 4'd15, 1'b0, 1'b0, 5'(cnt), err, 4'(first)};
      exp_q[d].push_back(r);
   endtask

   task automatic check_outputs(input int d);
      logic [18:0] act;
      logic [18:0] exp_v;
      rec_t e;
      act = {done_o[d], valid_o[d], busy_o[d], vec_o[d], sop_o[d], pos_o[d],
             cnt_o[d], err_o[d], first_o[d]};
      checks++;
      if (valid_o[d] || done_o[d]) begin
         if (exp_q[d].size() == 0) begin
            failures++;
            $display("FAIL unexpected_output dut=%0d actual=%h required=no output", d, act);
         end else begin
            e = exp_q[d].pop_front();
            exp_v = {e.is_done, ~e.is_done, ~e.is_done, e.vec, e.sop, e.pos,
                     e.cnt, e.err, e.first};
            if (act !== exp_v) begin
               failures++;
               $display("FAIL stream dut=%0d actual=%h required=%h", d, act, exp_v);
            end
            if (e.is_done) held[d] = e;
         end
      end else if (exp_q[d].size() != 0) begin
         failures++;
         $display("FAIL missing_output dut=%0d actual=%h pending=%0d", d, act, exp_q[d].size());
      end else begin
         exp_v = {3'b000, held[d].vec, 2'b00, held[d].cnt, held[d].err, held[d].first};
         if (act !== exp_v) begin
            failures++;
            $display("FAIL hold dut=%0d actual=%h required=%h", d, act, exp_v);
         end
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      initial begin
         forever begin
            @(posedge clk);
            #1;
            check_outputs(g);
         end
      end
   end

   task automatic issue_start(input int d, input logic [15:0] mn, input logic [15:0] mx);
      @(negedge clk);
      min_s[d]   = mn;
      max_s[d]   = mx;
      start_s[d] = 1'b1;
      push_sweep(d, mn, mx);
      @(negedge clk);
      start_s[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (exp_q[d].size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q[d].size() != 0) begin
         failures++;
         $display("FAIL sweep_timeout dut=%0d pending=%0d required=0", d, exp_q[d].size());
         exp_q[d].delete();
      end
   endtask

   task automatic check_zero(input int d, input string name);
      logic [18:0] act;
      act = {done_o[d], valid_o[d], busy_o[d], vec_o[d], sop_o[d], pos_o[d],
             cnt_o[d], err_o[d], first_o[d]};
      checks++;
      if (act !== 19'h0) begin
         failures++;
         $display("FAIL %s dut=%0d actual=%h required=0", name, d, act);
      end
   endtask

   initial begin
      logic [15:0] mn;
      logic [15:0] mx;
      int d;
      for (int i = 0; i < 2; i++) begin
         rst_s[i]   = 1'b1;
         start_s[i] = 1'b0;
         min_s[i]   = 16'h0;
         max_s[i]   = 16'h0;
         held[i]    = '0;
      end
      repeat (3) @(negedge clk);
      check_zero(0, "reset_state");
      check_zero(1, "reset_state");
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;

      // Directed scenarios.
      issue_start(0, 16'hD569, 16'h2A96); wait_done(0);
      issue_start(0, 16'hD569, 16'h2A97); wait_done(0);
      issue_start(0, 16'hFFFF, 16'hFFFF); wait_done(0);
      issue_start(1, 16'hD569, 16'h2A96); wait_done(1);
      issue_start(1, 16'hFFFF, 16'h0000); wait_done(1);

      // Reset while vector 7 is shown.
      issue_start(0, 16'hD569, 16'h2A97);
      repeat (7) @(negedge clk);
      checks++;
      if (vec_o[0] !== 4'd7) begin
         failures++;
         $display("FAIL vec_before_reset actual=%0d required=7", vec_o[0]);
      end
      rst_s[0] = 1'b1;
      exp_q[0].delete();
      held[0] = '0;
      @(negedge clk);
      check_zero(0, "mid_sweep_reset");
      rst_s[0] = 1'b0;
      issue_start(0, 16'hD569, 16'h2A96); wait_done(0);

      // start pulse and mask change during a sweep must be ignored.
      issue_start(0, 16'hD569, 16'h2A97);
      repeat (5) @(negedge clk);
      start_s[0] = 1'b1;
      min_s[0]   = 16'h0000;
      @(negedge clk);
      start_s[0] = 1'b0;
      wait_done(0);
      repeat (3) @(negedge clk);
      issue_start(0, 16'h0000, 16'h2A97); wait_done(0);

      // Randomised sweeps on both instances.
      for (int it = 0; it < 24; it++) begin
         d  = int'($urandom_range(0, 1));
         mn = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       mx = ~mn;
            1:       mx = ~mn ^ (16'h0001 << $urandom_range(0, 15));
            default: mx = 16'($urandom);
         endcase
         issue_start(d, mn, mx);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            start_s[d] = 1'b1;
            min_s[d]   = 16'($urandom);
            max_s[d]   = 16'($urandom);
            @(negedge clk);
            start_s[d] = 1'b0;
         end
         wait_done(d);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
